// File: rtl/alu_share_arbiter_if.sv
// Handshake and ALU bus bundle for the shared-ALU arbiter.
// master = requesters/ALU/consumer side, slave = arbiter side.
interface alu_share_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [WIDTH-1:0] req_a0;
    logic [WIDTH-1:0] req_a1;
    logic [WIDTH-1:0] req_b0;
    logic [WIDTH-1:0] req_b1;
    logic [OPW-1:0]   req_op0;
    logic [OPW-1:0]   req_op1;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [OPW-1:0]   alu_ctrl;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;

    logic             resp_valid;
    logic             resp_ready;
    logic             resp_id;
    logic [WIDTH-1:0] resp_result;
    logic             resp_zero;
    logic             resp_err;

    modport master (
        output req_valid,
        input  req_ready,
        output req_a0,
        output req_a1,
        output req_b0,
        output req_b1,
        output req_op0,
        output req_op1,
        input  alu_a,
        input  alu_b,
        input  alu_ctrl,
        output alu_result,
        output alu_zero,
        input  resp_valid,
        output resp_ready,
        input  resp_id,
        input  resp_result,
        input  resp_zero,
        input  resp_err
    );

    modport slave (
        input  req_valid,
        output req_ready,
        input  req_a0,
        input  req_a1,
        input  req_b0,
        input  req_b1,
        input  req_op0,
        input  req_op1,
        output alu_a,
        output alu_b,
        output alu_ctrl,
        input  alu_result,
        input  alu_zero,
        output resp_valid,
        input  resp_ready,
        output resp_id,
        output resp_result,
        output resp_zero,
        output resp_err
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// One transaction in flight: IDLE accepts, EXEC captures, RESP holds the response.
module alu_share_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic               clk,
    input  logic               reset,
    alu_share_arbiter_if.slave bus
);
    localparam logic [OPW-1:0] OP_AND = OPW'(4'b0000);
    localparam logic [OPW-1:0] OP_OR  = OPW'(4'b0001);
    localparam logic [OPW-1:0] OP_ADD = OPW'(4'b0010);
    localparam logic [OPW-1:0] OP_SUB = OPW'(4'b0110);
    localparam logic [OPW-1:0] OP_SLT = OPW'(4'b0111);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;

    logic             last_grant;
    logic [1:0]       gnt;
    logic [1:0]       ready;
    logic             accept;
    logic             gnt_id;
    logic             rvalid;

    logic             id_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [OPW-1:0]   op_q;
    logic             legal;

    logic             rid_q;
    logic [WIDTH-1:0] res_q;
    logic             zero_q;
    logic             err_q;

    // Round-robin pick: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        gnt = 2'b00;
        unique case (1'b1)
            (bus.req_valid[0] && !bus.req_valid[1]): gnt = 2'b01;
            (bus.req_valid[1] && !bus.req_valid[0]): gnt = 2'b10;
            (bus.req_valid[0] &&  bus.req_valid[1]):
                gnt = last_grant ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    assign gnt_id = gnt[1];

    // Only the five ALU codes are trusted; anything else yields an error response.
    assign legal = (op_q == OP_AND) || (op_q == OP_OR)
                || (op_q == OP_ADD) || (op_q == OP_SUB)
                || (op_q == OP_SLT);

    // State register; reset abandons any in-flight transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs; ready never looks at resp_ready.
    always_comb begin
        state_d = state_q;
        ready   = 2'b00;
        accept  = 1'b0;
        rvalid  = 1'b0;
        unique case (state_q)
            IDLE: begin
                ready  = reset ? 2'b00 : gnt;
                accept = |gnt;
                if (|gnt) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = RESP;
            end
            RESP: begin
                rvalid = 1'b1;
                if (bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Latch the winner's operands; these also drive the ALU in every state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
            id_q       <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
        end else if (accept) begin
            last_grant <= gnt_id;
            id_q       <= gnt_id;
            a_q        <= gnt_id ? bus.req_a1  : bus.req_a0;
            b_q        <= gnt_id ? bus.req_b1  : bus.req_b0;
            op_q       <= gnt_id ? bus.req_op1 : bus.req_op0;
        end
    end

    // Capture the ALU output at the end of EXEC; held until the response is taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rid_q  <= 1'b0;
            res_q  <= '0;
            zero_q <= 1'b0;
            err_q  <= 1'b0;
        end else if (state_q == EXEC) begin
            rid_q <= id_q;
            if (legal) begin
                res_q  <= bus.alu_result;
                zero_q <= bus.alu_zero;
                err_q  <= 1'b0;
            end else begin
                res_q  <= '0;
                zero_q <= 1'b1;
                err_q  <= 1'b1;
            end
        end
    end

    assign bus.req_ready   = ready;
    assign bus.alu_a       = a_q;
    assign bus.alu_b       = b_q;
    assign bus.alu_ctrl    = op_q;
    assign bus.resp_valid  = rvalid;
    assign bus.resp_id     = rid_q;
    assign bus.resp_result = res_q;
    assign bus.resp_zero   = zero_q;
    assign bus.resp_err    = err_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter.
// Transaction-level reference model plus directed literal cases.
module tb_alu_share_arbiter;
    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   cyc;

    alu_share_arbiter_if #(.WIDTH(32), .OPW(4)) bus ();

    alu_share_arbiter #(.WIDTH(32), .OPW(4)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // External ALU: untrusted garbage for codes it does not implement.
    logic [31:0] alu_r;
    logic        alu_z;
    always_comb begin
        alu_r = 32'hDEADBEEF;
        alu_z = 1'b0;
        case (bus.alu_ctrl)
            4'b0000: alu_r = bus.alu_a & bus.alu_b;
            4'b0001: alu_r = bus.alu_a | bus.alu_b;
            4'b0010: alu_r = bus.alu_a + bus.alu_b;
            4'b0110: alu_r = bus.alu_a - bus.alu_b;
            4'b0111: alu_r = {31'd0, bus.alu_a < bus.alu_b};
            default: alu_r = 32'hDEADBEEF;
        endcase
        if (alu_r != 32'hDEADBEEF) alu_z = (alu_r == 32'd0);
    end
    assign bus.alu_result = alu_r;
    assign bus.alu_zero   = alu_z;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    // Reference result: {err, zero, result}.
    function automatic logic [33:0] ref_alu(input logic [3:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] r;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: r = a + b;
            4'b0110: r = a - b;
            4'b0111: r = (a < b) ? 32'd1 : 32'd0;
            default: return {1'b1, 1'b1, 32'd0};
        endcase
        return {1'b0, r == 32'd0, r};
    endfunction

    typedef struct {
        bit          id;
        int          acc;
        logic [31:0] res;
        bit          z;
        bit          e;
    } txn_t;

    txn_t        q[$];
    bit          acc_log[$];
    bit          m_last;
    logic [31:0] m_a;
    logic [31:0] m_b;
    logic [3:0]  m_op;

    // Compare process: model predicts every output once per cycle.
    always @(negedge clk) begin
        logic [1:0]  er;
        logic        ev;
        logic [33:0] rr;
        txn_t        t;
        if (|(bus.req_valid & bus.req_ready))
            acc_log.push_back(bus.req_ready[1]);
        if (reset) begin
            q.delete();
            m_last = 1'b1;
            m_a = 0;
            m_b = 0;
            m_op = 0;
            chk("rst_req_ready", 32'(bus.req_ready), 0);
            chk("rst_resp_valid", 32'(bus.resp_valid), 0);
            chk("rst_resp_result", bus.resp_result, 0);
            chk("rst_resp_flags",
                32'({bus.resp_zero, bus.resp_err, bus.resp_id}), 0);
            chk("rst_alu_a", bus.alu_a, 0);
            chk("rst_alu_b", bus.alu_b, 0);
            chk("rst_alu_ctrl", 32'(bus.alu_ctrl), 0);
        end else begin
            er = 2'b00;
            if (q.size() == 0) begin
                case (bus.req_valid)
                    2'b01: er = 2'b01;
                    2'b10: er = 2'b10;
                    2'b11: er = m_last ? 2'b01 : 2'b10;
                    default: er = 2'b00;
                endcase
            end
            chk("req_ready", 32'(bus.req_ready), 32'(er));
            chk("alu_a", bus.alu_a, m_a);
            chk("alu_b", bus.alu_b, m_b);
            chk("alu_ctrl", 32'(bus.alu_ctrl), 32'(m_op));
            ev = (q.size() > 0) && (cyc >= q[0].acc + 1);
            chk("resp_valid", 32'(bus.resp_valid), 32'(ev));
            if (ev) begin
                chk("resp_result", bus.resp_result, q[0].res);
                chk("resp_zero", 32'(bus.resp_zero), 32'(q[0].z));
                chk("resp_err", 32'(bus.resp_err), 32'(q[0].e));
                chk("resp_id", 32'(bus.resp_id), 32'(q[0].id));
                if (bus.resp_ready) void'(q.pop_front());
            end
            if (er != 2'b00) begin
                t.id = er[1];
                t.acc = cyc + 1;
                m_a = t.id ? bus.req_a1 : bus.req_a0;
                m_b = t.id ? bus.req_b1 : bus.req_b0;
                m_op = t.id ? bus.req_op1 : bus.req_op0;
                rr = ref_alu(m_op, m_a, m_b);
                t.e = rr[33];
                t.z = rr[32];
                t.res = rr[31:0];
                q.push_back(t);
                m_last = t.id;
            end
        end
    end

    task automatic txn(input int r, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op, input logic [31:0] er,
                       input logic ez, input logic ee, input string nm,
                       output int rw, output int lat);
        if (r == 0) begin
            bus.req_a0 = a; bus.req_b0 = b; bus.req_op0 = op;
        end else begin
            bus.req_a1 = a; bus.req_b1 = b; bus.req_op1 = op;
        end
        bus.req_valid[r] = 1'b1;
        for (rw = 1; rw <= 20; rw++) begin
            @(negedge clk);
            if (bus.req_ready[r]) break;
        end
        if (rw > 20) begin
            chk({nm, "_grant_timeout"}, 1, 0);
            bus.req_valid[r] = 1'b0;
            lat = 0;
            return;
        end
        @(posedge clk);
        #1 bus.req_valid[r] = 1'b0;
        for (lat = 1; lat <= 20; lat++) begin
            @(negedge clk);
            if (bus.resp_valid) break;
        end
        if (lat > 20) begin
            chk({nm, "_resp_timeout"}, 1, 0);
            return;
        end
        chk({nm, "_result"}, bus.resp_result, er);
        chk({nm, "_zero"}, 32'(bus.resp_zero), 32'(ez));
        chk({nm, "_err"}, 32'(bus.resp_err), 32'(ee));
        chk({nm, "_id"}, 32'(bus.resp_id), r);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rw;
        int lat;
        int n;
        logic [3:0] ops[7];
        ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
                4'b1111, 4'b0011};
        checks = 0;
        errors = 0;
        cyc = 0;
        reset = 1'b1;
        bus.req_valid = 2'b00;
        bus.req_a0 = 0; bus.req_b0 = 0; bus.req_op0 = 0;
        bus.req_a1 = 0; bus.req_b1 = 0; bus.req_op1 = 0;
        bus.resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        txn(0, 5, 7, 4'b0010, 12, 0, 0, "add5_7", rw, lat);
        chk("ready_same_cycle", rw, 1);
        chk("latency", lat, 2);
        txn(0, 32'hFFFFFFFF, 1, 4'b0010, 0, 1, 0, "add_wrap", rw, lat);
        txn(0, 3, 5, 4'b0110, 32'hFFFFFFFE, 0, 0, "sub3_5", rw, lat);
        txn(1, 3, 5, 4'b0111, 1, 0, 0, "slt3_5", rw, lat);
        txn(0, 1, 1, 4'b1111, 0, 1, 1, "illegal", rw, lat);

        // Response backpressure with a competing requester waiting.
        bus.resp_ready = 1'b0;
        bus.req_a0 = 10; bus.req_b0 = 20; bus.req_op0 = 4'b0010;
        bus.req_a1 = 7; bus.req_b1 = 7; bus.req_op1 = 4'b0110;
        bus.req_valid = 2'b01;
        @(negedge clk);
        chk("bp_grant0", 32'(bus.req_ready), 1);
        @(posedge clk);
        #1 bus.req_valid = 2'b10;
        @(negedge clk);
        chk("bp_exec_ready", 32'(bus.req_ready), 0);
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold_valid", 32'(bus.resp_valid), 1);
            chk("bp_hold_result", bus.resp_result, 30);
            chk("bp_hold_ready", 32'(bus.req_ready), 0);
        end
        @(posedge clk);
        #1 bus.resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_resp", 32'(bus.resp_valid), 1);
        @(negedge clk);
        chk("bp_idle_grant1", 32'(bus.req_ready), 2);
        @(posedge clk);
        #1 bus.req_valid = 2'b00;
        repeat (4) @(posedge clk);
        #1;

        // Reset while in EXEC.
        bus.req_a0 = 9; bus.req_b0 = 9; bus.req_op0 = 4'b0010;
        bus.req_valid = 2'b01;
        @(negedge clk);
        chk("k1_grant", 32'(bus.req_ready), 1);
        @(posedge clk);
        #1 bus.req_valid = 2'b00;
        chk("k1_alu_a_pre", bus.alu_a, 9);
        reset = 1'b1;
        #1;
        chk("k1_async_alu_a", bus.alu_a, 0);
        chk("k1_async_ctrl", 32'(bus.alu_ctrl), 0);
        chk("k1_async_valid", 32'(bus.resp_valid), 0);
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("k1_no_resp", 32'(bus.resp_valid), 0);
        end

        // Reset while in RESP.
        bus.resp_ready = 1'b0;
        bus.req_a1 = 20; bus.req_b1 = 1; bus.req_op1 = 4'b0110;
        bus.req_valid = 2'b10;
        @(negedge clk);
        @(posedge clk);
        #1 bus.req_valid = 2'b00;
        @(posedge clk);
        @(negedge clk);
        chk("k2_in_resp", 32'(bus.resp_valid), 1);
        chk("k2_result", bus.resp_result, 19);
        #2 reset = 1'b1;
        #1;
        chk("k2_async_valid", 32'(bus.resp_valid), 0);
        chk("k2_async_result", bus.resp_result, 0);
        chk("k2_async_id", 32'(bus.resp_id), 0);
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        bus.resp_ready = 1'b1;

        // First tie after reset, then continuous contention.
        acc_log.delete();
        bus.req_a0 = 1; bus.req_b0 = 2; bus.req_op0 = 4'b0001;
        bus.req_a1 = 8; bus.req_b1 = 8; bus.req_op1 = 4'b0110;
        bus.req_valid = 2'b11;
        @(negedge clk);
        chk("first_tie", 32'(bus.req_ready), 1);
        n = 0;
        while (acc_log.size() < 6 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1 bus.req_valid = 2'b00;
        chk("rr_count", acc_log.size() >= 6, 1);
        for (int i = 0; i < 6 && i < acc_log.size(); i++)
            chk($sformatf("rr_id%0d", i), 32'(acc_log[i]), i % 2);
        repeat (5) @(posedge clk);
        #1;

        // Randomized traffic.
        for (int k = 0; k < 600; k++) begin
            bus.req_valid = 2'($urandom_range(0, 3));
            bus.resp_ready = ($urandom_range(0, 3) != 0);
            bus.req_a0 = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 4));
            bus.req_b0 = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 4));
            bus.req_a1 = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 4));
            bus.req_b1 = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 4));
            bus.req_op0 = ops[$urandom_range(0, 6)];
            bus.req_op1 = ops[$urandom_range(0, 6)];
            @(posedge clk);
            #1;
        end
        bus.req_valid = 2'b00;
        bus.resp_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
